// File: rtl/led_flash_pkg.sv
// led_flash shared types: display modes, LED width and the
// pattern each mode starts from when it is entered.
package led_flash_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_SHIFT = 2'd2,
        MODE_COUNT = 2'd3
    } mode_e;

    localparam logic [LED_W-1:0] PAT_OFF   = 4'b0000;
    localparam logic [LED_W-1:0] PAT_BLINK = 4'b1111;
    localparam logic [LED_W-1:0] PAT_SHIFT = 4'b0001;
    localparam logic [LED_W-1:0] PAT_COUNT = 4'b0000;

    function automatic logic [LED_W-1:0] init_pat(mode_e m);
        logic [LED_W-1:0] p;
        p = PAT_OFF;
        unique case (m)
            MODE_OFF:   p = PAT_OFF;
            MODE_BLINK: p = PAT_BLINK;
            MODE_SHIFT: p = PAT_SHIFT;
            MODE_COUNT: p = PAT_COUNT;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_flash_if.sv
// Front-panel bundle: raw push-button in, LED drive and
// debounced button level out.
interface led_flash_if;
    import led_flash_pkg::*;

    logic             i_PMOD1_P1;
    logic [LED_W-1:0] o_LED;
    logic             btn_db;

    modport master (
        output i_PMOD1_P1,
        input  o_LED,
        input  btn_db
    );

    modport slave (
        input  i_PMOD1_P1,
        output o_LED,
        output btn_db
    );

endinterface

// File: rtl/led_flash_debounce.sv
// Active-low button conditioner: 2-flop synchroniser, stability
// counter and a one-cycle pulse on each accepted press.
module led_flash_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic btn_db_o,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          press_q, press_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            db_q    <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        sync_d = {sync_q[0], btn_i};
        cnt_d  = '0;
        db_d   = db_q;
        // The counter only survives while the level keeps disagreeing.
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = db_q & ~db_d;
    end

    assign btn_db_o = db_q;
    assign press_o  = press_q;

endmodule

// File: rtl/led_flash.sv
// Button-stepped LED pattern generator: mode register, animation
// prescaler and per-mode pattern register.
module led_flash
    import led_flash_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 4
) (
    input  logic        i_SCLK,
    input  logic        i_RESET_SYSB,
    led_flash_if.slave  io
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic             press;
    logic             btn_db;
    logic             tick;
    mode_e            mode_q, mode_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [LED_W-1:0] pat_q, pat_d;

    led_flash_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i   (i_SCLK),
        .rst_ni  (i_RESET_SYSB),
        .btn_i   (io.i_PMOD1_P1),
        .btn_db_o(btn_db),
        .press_o (press)
    );

    always_ff @(posedge i_SCLK) begin
        if (!i_RESET_SYSB) begin
            mode_q <= MODE_OFF;
            pre_q  <= '0;
            pat_q  <= PAT_OFF;
        end else begin
            mode_q <= mode_d;
            pre_q  <= pre_d;
            pat_q  <= pat_d;
        end
    end

    assign tick = (pre_q == PRE_MAX);

    always_comb begin
        mode_d = mode_q;
        pre_d  = pre_q + 1'b1;
        pat_d  = pat_q;
        if (tick) begin
            pre_d = '0;
        end
        // A press restarts the animation, so a coincident tick is lost.
        if (press) begin
            mode_d = mode_e'(mode_q + 2'd1);
            pre_d  = '0;
            pat_d  = init_pat(mode_d);
        end else if (tick) begin
            unique case (mode_q)
                MODE_OFF:   pat_d = PAT_OFF;
                MODE_BLINK: pat_d = ~pat_q;
                MODE_SHIFT: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                MODE_COUNT: pat_d = pat_q + 1'b1;
            endcase
        end
    end

    assign io.o_LED  = pat_q;
    assign io.btn_db = btn_db;

endmodule

// File: tb/tb_led_flash.sv
// Randomised bench for led_flash against a behavioural model:
// presses counted from the sample history, LEDs from elapsed ticks.
module tb_led_flash;
    import led_flash_pkg::*;

    localparam int DB = 4;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    led_flash_if bus();

    led_flash #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV       (TD)
    ) dut (
        .i_SCLK      (clk),
        .i_RESET_SYSB(rst_n),
        .io          (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    int m_mode;
    int m_n;
    bit m_db;
    bit m_pend;
    bit m_sy1;
    bit m_sy2;
    bit m_hist[$];

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t",
                      tag, got, exp, $time);
    endtask

    function automatic logic [3:0] pat(input int mode, input int k);
        logic [3:0] p;
        p = 4'b0000;
        case (mode)
            1: p = (k % 2 == 0) ? 4'b1111 : 4'b0000;
            2: p = 4'(1 << (k % 4));
            3: p = 4'(k % 16);
            default: p = 4'b0000;
        endcase
        return p;
    endfunction

    task automatic model_edge(input bit b, input bit r);
        bit all_diff;
        if (!r) begin
            m_mode = 0;
            m_n = 0;
            m_db = 1'b1;
            m_pend = 1'b0;
            m_sy1 = 1'b1;
            m_sy2 = 1'b1;
            m_hist.delete();
        end else begin
            if (m_pend) begin
                m_mode = (m_mode + 1) % 4;
                m_n = 0;
            end else begin
                m_n++;
            end
            m_pend = 1'b0;
            m_hist.push_back(m_sy2);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            all_diff = (m_hist.size() == DB);
            foreach (m_hist[i]) if (m_hist[i] == m_db) all_diff = 1'b0;
            if (all_diff) begin
                m_pend = m_db;
                m_db = !m_db;
                m_hist.delete();
            end
            m_sy2 = m_sy1;
            m_sy1 = b;
        end
    endtask

    task automatic cyc(input bit b, input bit r, input string tag);
        bus.i_PMOD1_P1 = b;
        rst_n = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        chk(tag, bus.o_LED, pat(m_mode, m_n / TD));
        chk({tag, "/db"}, {3'b000, bus.btn_db}, {3'b000, m_db});
    endtask

    task automatic hold(input bit b, input int n, input string tag);
        repeat (n) cyc(b, 1'b1, tag);
    endtask

    initial begin
        bus.i_PMOD1_P1 = 1'b1;
        cyc(1'b1, 1'b0, "reset");
        cyc(1'b1, 1'b0, "reset");
        hold(1'b1, 10, "idle");
        chk("reset_led", bus.o_LED, 4'b0000);

        hold(1'b0, 6, "press1");
        chk("press1_pre", bus.o_LED, 4'b0000);
        cyc(1'b0, 1'b1, "press1");
        chk("press1_edge7", bus.o_LED, 4'b1111);
        hold(1'b0, 6, "press1");
        hold(1'b1, 20, "blink");

        hold(1'b0, 43, "press2");
        hold(1'b1, 20, "shift");

        hold(1'b0, 10, "press3");
        hold(1'b1, 80, "count");

        hold(1'b0, 10, "press4");
        hold(1'b1, 12, "off");
        chk("press4_off", bus.o_LED, 4'b0000);

        hold(1'b0, 3, "glitch");
        hold(1'b1, 12, "glitch");
        chk("glitch_off", bus.o_LED, 4'b0000);

        for (int i = 0; i < 40; i++) begin
            hold(1'b0, $urandom_range(1, 12), "rnd_lo");
            hold(1'b1, $urandom_range(1, 24), "rnd_hi");
        end

        cyc(1'b1, 1'b0, "rst2");
        cyc(1'b1, 1'b0, "rst2");
        hold(1'b1, 8, "rst2");
        hold(1'b0, 8, "to_blink");
        hold(1'b1, 8, "to_blink");
        hold(1'b0, 8, "to_shift");
        hold(1'b1, 10, "to_shift");
        cyc(1'b1, 1'b0, "rst_mid");
        chk("rst_mid_led", bus.o_LED, 4'b0000);
        cyc(1'b0, 1'b0, "rst_low");
        hold(1'b0, 6, "rel_low");
        chk("rel_low_pre", bus.o_LED, 4'b0000);
        cyc(1'b0, 1'b1, "rel_low");
        chk("rel_low_blink", bus.o_LED, 4'b1111);
        hold(1'b1, 20, "rel_blink");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
